// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the rx FIFO and its consumer.
// master = receiver/consumer side, slave = the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [DEPTH_LOG2:0] level;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                ovf_clr;

  modport master (
    output wr_data, wr_en, rd_ready, ovf_clr,
    input  rd_data, rd_valid, level, full, empty, overflow
  );

  modport slave (
    input  wr_data, wr_en, rd_ready, ovf_clr,
    output rd_data, rd_valid, level, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver.
// Define UART_RX_FIFO_OVF_EN to enable the sticky overflow flag.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                full_w;
  logic                empty_w;
  logic                push;
  logic                pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  assign pop  = !empty_w && bus.rd_ready;
  assign push = bus.wr_en && (!full_w || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data  = empty_w ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.rd_valid = !empty_w;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.level    = wr_ptr - rd_ptr;

`ifdef UART_RX_FIFO_OVF_EN
  logic overflow_q;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      overflow_q <= 1'b0;
    else if (bus.wr_en && full_w && !pop)
      overflow_q <= 1'b1;
    else if (bus.ovf_clr)
      overflow_q <= 1'b0;
  end

  assign bus.overflow = overflow_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued on write and
// compared against rd_data as they are popped.
module tb_uart_rx_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
`ifdef UART_RX_FIFO_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    exp_q.push_back(d);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0; bus.ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.level !== 5'd0 ||
        bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h level=%0d full=%b empty=%b ovf=%b, expected 0/00/0/0/1/0",
               bus.rd_valid, bus.rd_data, bus.level, bus.full, bus.empty, bus.overflow);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    push_byte(8'hA5);
    exp = exp_q[0];
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.level !== 5'd1 || bus.empty !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_visible: got valid=%b data=%h level=%0d empty=%b, expected 1/%h/1/0",
               bus.rd_valid, bus.rd_data, bus.level, bus.empty, exp);
    end
    void'(exp_q.pop_front());
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.level !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL single_popped: got valid=%b data=%h level=%0d, expected 0/00/0",
               bus.rd_valid, bus.rd_data, bus.level);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    n_cmp++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16) begin
      n_fail++;
      $display("[TB] FAIL fill_full: got full=%b level=%0d, expected 1/16", bus.full, bus.level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.empty !== !bus.rd_valid) begin
        n_fail++;
        $display("[TB] FAIL fill_drain[%0d]: got valid=%b data=%h, expected 1/%h", i, bus.rd_valid, bus.rd_data, exp);
      end
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL fill_empty: got empty=%b level=%0d, expected 1/0", bus.empty, bus.level);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    step();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.level !== 5'd16 || bus.overflow !== OVF_EN) begin
      n_fail++;
      $display("[TB] FAIL ovf_drop: got level=%0d ovf=%b, expected 16/%b", bus.level, bus.overflow, OVF_EN);
    end
    bus.ovf_clr = 1'b1;
    step();
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.level !== 5'd16) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear_full: got ovf=%b level=%0d, expected 0/16", bus.overflow, bus.level);
    end
    bus.wr_en = 1'b1; bus.wr_data = 8'hEF;
    step();
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== OVF_EN) begin
      n_fail++;
      $display("[TB] FAIL ovf_set_wins: got ovf=%b, expected %b", bus.overflow, OVF_EN);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_data !== exp || bus.overflow !== OVF_EN) begin
        n_fail++;
        $display("[TB] FAIL ovf_drain[%0d]: got data=%h ovf=%b, expected %h/%b", i, bus.rd_data, bus.overflow, exp, OVF_EN);
      end
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
    end
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_cleared: got ovf=%b valid=%b, expected 0/0", bus.overflow, bus.rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.rd_data !== exp) begin
      n_fail++;
      $display("[TB] FAIL simul_head: got data=%h, expected %h", bus.rd_data, exp);
    end
    bus.rd_ready = 1'b1;
    push_byte(8'h55);
    bus.rd_ready = 1'b0;
    n_cmp++;
    if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL simul_full: got level=%0d full=%b ovf=%b, expected 16/1/0", bus.level, bus.full, bus.overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        n_fail++;
        $display("[TB] FAIL simul_drain[%0d]: got valid=%b data=%h, expected 1/%h", i, bus.rd_valid, bus.rd_data, exp);
      end
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    int max_level = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) begin
        push_byte(8'($urandom_range(0, 255)));
        if (int'(bus.level) > max_level) max_level = int'(bus.level);
        n_cmp++;
        if (int'(bus.level) !== exp_q.size()) begin
          n_fail++;
          $display("[TB] FAIL wrap_level_push: got level=%0d, expected %0d", bus.level, exp_q.size());
        end
      end
      for (int i = 0; i < 5; i++) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL wrap_data[%0d.%0d]: got valid=%b data=%h, expected 1/%h", r, i, bus.rd_valid, bus.rd_data, exp);
        end
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
      end
    end
    n_cmp++;
    if (max_level > 5 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_max_level: got max=%0d empty=%b, expected <=5/1", max_level, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i));
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    step();
    rst = 1'b0; bus.wr_en = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got level=%0d valid=%b ovf=%b, expected 0/0/0", bus.level, bus.rd_valid, bus.overflow);
    end
    push_byte(8'h3C);
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.level !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_after: got valid=%b data=%h level=%0d, expected 1/%h/1", bus.rd_valid, bus.rd_data, bus.level, exp);
    end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle `done` strobe into a power-of-two FIFO, and offers the bytes to the consuming logic through a valid/ready handshake. It decouples the bit-rate receiver from a consumer that may stall for many byte times, and reports fill level and overrun.

## Interface
- `DATA_W`, 8: byte width; matches the receiver's `data` output.
- `DEPTH_LOG2`, 4: log2 of FIFO depth (DEPTH = 16). Legal range 1–8.

- `clk`  in  1: single clock, same domain as the UART receiver.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_data`  in  DATA_W: byte from the receiver's `data`.
- `wr_en`  in  1: one-cycle write strobe; connects to the receiver's `done`.
- `rd_data`  out  DATA_W: head-of-FIFO byte. Forced to 0 while `rd_valid` = 0.
- `rd_valid`  out  1: FIFO non-empty; `rd_data` is valid.
- `rd_ready`  in  1: consumer accepts the byte. Pop occurs when `rd_valid && rd_ready`.
- `level`  out  DEPTH_LOG2+1: current occupancy, 0..DEPTH.
- `full`  out  1: `level == DEPTH`.
- `empty`  out  1: `level == 0`; always equals `!rd_valid`.
- `overflow`  out  1: sticky overrun flag (see Configuration).
- `ovf_clr`  in  1: clears `overflow`.

## Operation
- Storage is a DEPTH-entry array, not reset. `wr_ptr` and `rd_ptr` are each DEPTH_LOG2+1 bits and wrap naturally modulo 2·DEPTH.
- Full: pointer MSBs differ and lower bits are equal. Empty: pointers are equal.
- `level = wr_ptr - rd_ptr`, computed modulo 2^(DEPTH_LOG2+1).
- `rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]]` when not empty, else 0. This is first-word-fall-through with a combinational read.
- Push condition: `wr_en && (!full || pop)`. On push, write `mem[wr_ptr]` and increment `wr_ptr`.
- Pop condition: `rd_valid && rd_ready`. On pop, increment `rd_ptr`.
- Simultaneous push and pop:
  - Both pointers advance; `level` is unchanged.
  - This also holds when the FIFO is full: the pop frees the slot in the same edge.
- `wr_en` while empty with `rd_ready` = 1: push only, because pop requires `rd_valid`. The byte is visible the next cycle.
- `wr_en` while full with no pop:
  - The byte is dropped and the pointers are unchanged.
  - The overflow event is raised.
- `rd_ready` while empty: no effect.
- No internal state machine beyond the pointer pair and the overflow flag. All outputs derive from the registered state.

## Timing
- Reset values: `rd_data` = 0, `rd_valid` = 0, `level` = 0, `full` = 0, `empty` = 1, `overflow` = 0. The pointers are 0.
- Reset mid-operation: on the next edge the FIFO empties and all buffered bytes are discarded. A `wr_en` in the reset cycle is ignored.
- Write-to-read latency is 1 cycle:
  - A byte strobed at edge N is on `rd_data`, with `rd_valid` = 1, after edge N.
  - It can be popped at edge N+1.
- `level`, `full` and `empty` update on the same edge as the push or pop that changes them.
- Back-to-back `wr_en` on consecutive cycles is supported, even though the receiver never issues that at normal baud.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- Macro: `UART_RX_FIFO_OVF_EN`.
- When defined:
  - `overflow` is set on the edge after a dropped write.
  - It stays set until `ovf_clr` is sampled high.
  - If a drop and `ovf_clr` occur in the same cycle, set wins.
- When undefined:
  - `overflow` is tied to 0 and `ovf_clr` is ignored.
  - Writes while full are still dropped silently, with identical pointer behaviour.

## Test plan
- Reset, then `wr_en` with 0xA5 and `rd_ready` = 0.
  - Next cycle: `rd_valid` = 1, `rd_data` = 0xA5, `level` = 1, `empty` = 0.
  - Then pulse `rd_ready`: `rd_valid` = 0, `rd_data` = 0, `level` = 0.
- Write 0x00..0x0F with no reads.
  - `full` = 1 and `level` = 16.
  - Reads return 0x00..0x0F in order.
  - `empty` = 1 after the 16th pop.
- Full FIFO, then write 0xEE with no pop.
  - 0xEE is discarded and `level` stays 16.
  - With the macro defined, `overflow` = 1 and remains set through the drain.
  - `ovf_clr` clears it to 0.
  - Without the macro, `overflow` stays 0.
- Full FIFO, `wr_en` (0x55) and `rd_ready` in the same cycle.
  - `level` stays 16 and `overflow` stays 0.
  - Draining yields 0x01..0x0F, then 0x55.
- Wrap-around: 40 push/pop pairs with the occupancy oscillating between 0 and 5.
  - The data sequence is preserved.
  - `level` never exceeds 5.
- Load 7 bytes, then assert `rst` for one cycle with `wr_en` high.
  - `level` = 0, `rd_valid` = 0 and `overflow` = 0 after the edge.
  - The next write 0x3C reads back as 0x3C.
